// File: rtl/pdp_cal1d_pkg.sv
// Shared types and widths for the PDP 1D pooling calculation blocks.
package pdp_cal1d_pkg;

    localparam int unsigned PDP_FP17_DW     = 17;
    localparam int unsigned PDP_CAL1D_LANES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StWait,
        StOut
    } pdp_cal1d_state_e;

endpackage

// File: rtl/cal1d_fp16_pool_sum_ctrl.sv
// Window sequencer for 1D fp16 sum pooling over a shared external 4-lane fp17 adder.
// NVDLA_PDP_SUM_OVERLAP_EN: accept the next window's first element during the output handshake.
module cal1d_fp16_pool_sum_ctrl
    import pdp_cal1d_pkg::*;
#(
    parameter int unsigned LANES = PDP_CAL1D_LANES,
    parameter int unsigned DW    = PDP_FP17_DW,
    parameter int unsigned KW    = 3
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rstn,
    input  logic [KW-1:0]       cfg_kernel_width,
    input  logic                dat_in_pvld,
    output logic                dat_in_prdy,
    input  logic [LANES*DW-1:0] dat_in_pd,
    output logic                add_in_pvld,
    input  logic                add_in_prdy,
    output logic [LANES*DW-1:0] add_a_pd,
    output logic [LANES*DW-1:0] add_b_pd,
    input  logic                add_out_pvld,
    output logic                add_out_prdy,
    input  logic [LANES*DW-1:0] add_out_pd,
    output logic                sum_out_pvld,
    input  logic                sum_out_prdy,
    output logic [LANES*DW-1:0] sum_out_pd,
    output logic                busy
);

    pdp_cal1d_state_e    state_q, state_d;
    logic [LANES*DW-1:0] acc_q, acc_d;
    logic [KW-1:0]       cnt_q, cnt_d;
    logic [KW-1:0]       kw_q, kw_d;
    logic                accept;

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            state_q <= StIdle;
            acc_q   <= '0;
            cnt_q   <= '0;
            kw_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            kw_q    <= kw_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        kw_d         = kw_q;
        accept       = 1'b0;
        dat_in_prdy  = 1'b0;
        add_in_pvld  = 1'b0;
        add_a_pd     = '0;
        add_b_pd     = '0;
        add_out_prdy = 1'b0;
        sum_out_pvld = 1'b0;
        sum_out_pd   = '0;

        unique case (state_q)
            StIdle: begin
                dat_in_prdy = 1'b1;
                accept      = dat_in_pvld;
            end
            StFeed: begin
                add_in_pvld = dat_in_pvld;
                dat_in_prdy = add_in_prdy;
                add_a_pd    = dat_in_pd;
                add_b_pd    = acc_q;
                if (dat_in_pvld && add_in_prdy) begin
                    cnt_d   = cnt_q + KW'(1);
                    state_d = StWait;
                end
            end
            StWait: begin
                add_out_prdy = 1'b1;
                if (add_out_pvld) begin
                    acc_d   = add_out_pd;
                    state_d = (cnt_q == kw_q) ? StOut : StFeed;
                end
            end
            StOut: begin
                sum_out_pvld = 1'b1;
                sum_out_pd   = acc_q;
                if (sum_out_prdy) begin
                    state_d = StIdle;
                end
`ifdef NVDLA_PDP_SUM_OVERLAP_EN
                dat_in_prdy = sum_out_prdy;
                accept      = sum_out_prdy && dat_in_pvld;
`endif
            end
            default: state_d = StIdle;
        endcase

        // The first element of a window bypasses the adder so its bits (incl. -0) survive.
        if (accept) begin
            acc_d   = dat_in_pd;
            cnt_d   = '0;
            kw_d    = cfg_kernel_width;
            state_d = (cfg_kernel_width == '0) ? StOut : StFeed;
        end

        if (!nvdla_core_rstn) begin
            dat_in_prdy  = 1'b0;
            add_in_pvld  = 1'b0;
            add_out_prdy = 1'b0;
            sum_out_pvld = 1'b0;
        end
    end

    assign busy = nvdla_core_rstn && (state_q != StIdle);

endmodule

// File: tb/tb_cal1d_fp16_pool_sum_ctrl.sv
// Directed bench for cal1d_fp16_pool_sum_ctrl with a latency-3 integer adder stub.
module tb_cal1d_fp16_pool_sum_ctrl;

    localparam int unsigned LANES = 4;
    localparam int unsigned DW    = 17;
    localparam int unsigned KW    = 3;
    localparam int unsigned W     = LANES * DW;
`ifdef NVDLA_PDP_SUM_OVERLAP_EN
    localparam int OUT_GAP = 1;
`else
    localparam int OUT_GAP = 2;
`endif

    logic          clk;
    logic          rstn;
    logic [KW-1:0] cfg_kernel_width;
    logic          dat_in_pvld, dat_in_prdy;
    logic [W-1:0]  dat_in_pd;
    logic          add_in_pvld, add_in_prdy;
    logic [W-1:0]  add_a_pd, add_b_pd;
    logic          add_out_pvld, add_out_prdy;
    logic [W-1:0]  add_out_pd;
    logic          sum_out_pvld, sum_out_prdy;
    logic [W-1:0]  sum_out_pd;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic         pend;
    int           dly;
    logic [W-1:0] res;
    logic [W-1:0]  out_pd_q[$];
    int            out_cyc_q[$];
    int            acc_cyc_q[$];
    logic [DW-1:0] b_q[$];

    cal1d_fp16_pool_sum_ctrl dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .cfg_kernel_width(cfg_kernel_width),
        .dat_in_pvld     (dat_in_pvld),
        .dat_in_prdy     (dat_in_prdy),
        .dat_in_pd       (dat_in_pd),
        .add_in_pvld     (add_in_pvld),
        .add_in_prdy     (add_in_prdy),
        .add_a_pd        (add_a_pd),
        .add_b_pd        (add_b_pd),
        .add_out_pvld    (add_out_pvld),
        .add_out_prdy    (add_out_prdy),
        .add_out_pd      (add_out_pd),
        .sum_out_pvld    (sum_out_pvld),
        .sum_out_prdy    (sum_out_prdy),
        .sum_out_pd      (sum_out_pd),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rep(input int v);
        logic [DW-1:0] e;
        e = DW'(v);
        return {LANES{e}};
    endfunction

    function automatic logic [W-1:0] lane_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int l = 0; l < LANES; l++) r[l*DW +: DW] = a[l*DW +: DW] + b[l*DW +: DW];
        return r;
    endfunction

    // Adder stub: result is presented on the third cycle after the operand handshake.
    assign add_out_pvld = pend && (dly == 0);
    assign add_out_pd   = res;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) begin
            pend <= 1'b0;
            dly  <= 0;
            res  <= '0;
        end else begin
            if (add_in_pvld && add_in_prdy) begin
                pend <= 1'b1;
                dly  <= 2;
                res  <= lane_add(add_a_pd, add_b_pd);
                b_q.push_back(add_b_pd[DW-1:0]);
            end else if (pend && dly != 0) begin
                dly <= dly - 1;
            end
            if (add_out_pvld && add_out_prdy) pend <= 1'b0;
        end
        if (dat_in_pvld && dat_in_prdy) acc_cyc_q.push_back(cyc);
        if (sum_out_pvld && sum_out_prdy) begin
            out_pd_q.push_back(sum_out_pd);
            out_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        out_pd_q.delete();
        out_cyc_q.delete();
        acc_cyc_q.delete();
        b_q.delete();
    endtask

    // Feeds elements start..start+n-1 (replicated on all lanes); entered at posedge+1.
    task automatic feed(input int start, input int n);
        for (int i = 0; i < n; i++) begin
            bit done;
            int k;
            done = 1'b0;
            k    = 0;
            dat_in_pvld = 1'b1;
            dat_in_pd   = rep(start + i);
            while (!done) begin
                #1;
                done = dat_in_prdy;
                @(posedge clk);
                #1;
                k++;
                if (!done && k > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL feed_timeout elem=%0d never accepted", start + i);
                    break;
                end
            end
        end
        dat_in_pvld = 1'b0;
    endtask

    task automatic wait_outs(input int n, input string name);
        int k;
        k = 0;
        while (out_pd_q.size() < n && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (out_pd_q.size() < n) begin
            failures++;
            $display("FAIL %s_out_timeout got=%0d outputs required=%0d", name, out_pd_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dat_in_prdy, add_in_pvld, add_out_prdy, sum_out_pvld, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_hs got=%b required=00000",
                     {dat_in_prdy, add_in_pvld, add_out_prdy, sum_out_pvld, busy});
        end
        checks++;
        if ({add_a_pd, add_b_pd, sum_out_pd} !== '0) begin
            failures++;
            $display("FAIL reset_pd got a=%h b=%h sum=%h required=0", add_a_pd, add_b_pd, sum_out_pd);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (dat_in_prdy !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got prdy=%b busy=%b required prdy=1 busy=0", dat_in_prdy, busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_kw0();
        clear_logs();
        cfg_kernel_width = 3'd0;
        feed(1, 2);
        wait_outs(2, "kw0");
        if (out_pd_q.size() >= 2 && acc_cyc_q.size() >= 2) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (out_pd_q[i] !== rep(i + 1)) begin
                    failures++;
                    $display("FAIL kw0_sum%0d got=%h required=%h", i, out_pd_q[i], rep(i + 1));
                end
                checks++;
                if (out_cyc_q[i] - acc_cyc_q[i] != 1) begin
                    failures++;
                    $display("FAIL kw0_latency%0d got=%0d required=1", i, out_cyc_q[i] - acc_cyc_q[i]);
                end
            end
        end
        checks++;
        if (b_q.size() != 0) begin
            failures++;
            $display("FAIL kw0_adder_used got=%0d transactions required=0", b_q.size());
        end
    endtask

    task automatic test_kw3_timing();
        logic [DW-1:0] exp_b[3];
        exp_b[0] = 17'd1;
        exp_b[1] = 17'd3;
        exp_b[2] = 17'd6;
        clear_logs();
        cfg_kernel_width = 3'd3;
        feed(1, 4);
        cfg_kernel_width = 3'd0;
        wait_outs(1, "kw3");
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (out_pd_q.size() != 1) begin
            failures++;
            $display("FAIL kw3_count got=%0d required=1", out_pd_q.size());
        end
        if (out_pd_q.size() >= 1 && acc_cyc_q.size() >= 1) begin
            checks++;
            if (out_pd_q[0] !== rep(10)) begin
                failures++;
                $display("FAIL kw3_sum got=%h required=%h", out_pd_q[0], rep(10));
            end
            checks++;
            if (out_cyc_q[0] - acc_cyc_q[0] != 13) begin
                failures++;
                $display("FAIL kw3_latency got=%0d required=13", out_cyc_q[0] - acc_cyc_q[0]);
            end
        end
        checks++;
        if (b_q.size() != 3) begin
            failures++;
            $display("FAIL kw3_adder_count got=%0d required=3", b_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (b_q[i] !== exp_b[i]) begin
                    failures++;
                    $display("FAIL kw3_b%0d got=%0d required=%0d", i, b_q[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_add_stall();
        clear_logs();
        cfg_kernel_width = 3'd2;
        add_in_prdy = 1'b0;
        fork
            feed(1, 3);
            begin
                int k;
                k = 0;
                while (!busy && k < 50) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                for (int i = 0; i < 5; i++) begin
                    #1;
                    checks++;
                    if (dat_in_prdy !== 1'b0 || add_in_pvld !== 1'b1) begin
                        failures++;
                        $display("FAIL stall_cycle%0d got prdy=%b add_pvld=%b required prdy=0 add_pvld=1",
                                 i, dat_in_prdy, add_in_pvld);
                    end
                    @(posedge clk);
                    #1;
                end
                add_in_prdy = 1'b1;
            end
        join
        wait_outs(1, "stall");
        if (out_pd_q.size() >= 1) begin
            checks++;
            if (out_pd_q[0] !== rep(6)) begin
                failures++;
                $display("FAIL stall_sum got=%h required=%h", out_pd_q[0], rep(6));
            end
        end
        checks++;
        if (acc_cyc_q.size() != 3 || b_q.size() != 2) begin
            failures++;
            $display("FAIL stall_xfers got in=%0d add=%0d required in=3 add=2",
                     acc_cyc_q.size(), b_q.size());
        end
    endtask

    task automatic test_out_backpressure();
        int k;
        clear_logs();
        cfg_kernel_width = 3'd1;
        sum_out_prdy = 1'b0;
        feed(1, 2);
        k = 0;
        while (!sum_out_pvld && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        dat_in_pvld = 1'b1;
        dat_in_pd   = rep(85);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (sum_out_pvld !== 1'b1 || sum_out_pd !== rep(3) || dat_in_prdy !== 1'b0) begin
                failures++;
                $display("FAIL bp_cycle%0d got pvld=%b pd=%h prdy=%b required pvld=1 pd=%h prdy=0",
                         i, sum_out_pvld, sum_out_pd, dat_in_prdy, rep(3));
            end
            @(posedge clk);
            #1;
        end
        dat_in_pvld  = 1'b0;
        sum_out_prdy = 1'b1;
        wait_outs(1, "bp");
        if (out_pd_q.size() >= 1) begin
            checks++;
            if (out_pd_q[0] !== rep(3)) begin
                failures++;
                $display("FAIL bp_sum got=%h required=%h", out_pd_q[0], rep(3));
            end
        end
    endtask

    task automatic test_reset_in_wait();
        clear_logs();
        cfg_kernel_width = 3'd1;
        feed(1, 2);
        checks++;
        if (add_out_prdy !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_state got add_out_prdy=%b required=1", add_out_prdy);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({dat_in_prdy, add_in_pvld, add_out_prdy, sum_out_pvld, busy} !== 5'b0) begin
            failures++;
            $display("FAIL rst_wait_comb got=%b required=00000",
                     {dat_in_prdy, add_in_pvld, add_out_prdy, sum_out_pvld, busy});
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || dat_in_prdy !== 1'b1 || add_out_pvld !== 1'b0 ||
            {add_a_pd, add_b_pd, sum_out_pd} !== '0) begin
            failures++;
            $display("FAIL rst_wait_after got busy=%b prdy=%b add_out_pvld=%b b=%h required 0/1/0/0",
                     busy, dat_in_prdy, add_out_pvld, add_b_pd);
        end
        @(posedge clk);
        #1;
        clear_logs();
        cfg_kernel_width = 3'd0;
        feed(7, 1);
        wait_outs(1, "rst_wait");
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (out_pd_q.size() != 1) begin
            failures++;
            $display("FAIL rst_wait_count got=%0d required=1", out_pd_q.size());
        end else begin
            checks++;
            if (out_pd_q[0] !== rep(7)) begin
                failures++;
                $display("FAIL rst_wait_sum got=%h required=%h", out_pd_q[0], rep(7));
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        cfg_kernel_width = 3'd0;
        feed(1, 8);
        wait_outs(8, "b2b");
        if (out_pd_q.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (out_pd_q[i] !== rep(i + 1)) begin
                    failures++;
                    $display("FAIL b2b_sum%0d got=%h required=%h", i, out_pd_q[i], rep(i + 1));
                end
                if (i > 0) begin
                    checks++;
                    if (out_cyc_q[i] - out_cyc_q[i-1] != OUT_GAP) begin
                        failures++;
                        $display("FAIL b2b_gap%0d got=%0d required=%0d",
                                 i, out_cyc_q[i] - out_cyc_q[i-1], OUT_GAP);
                    end
                end
            end
        end
    endtask

    initial begin
        rstn             = 1'b0;
        cfg_kernel_width = '0;
        dat_in_pvld      = 1'b0;
        dat_in_pd        = '0;
        add_in_prdy      = 1'b1;
        sum_out_prdy     = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_kw0();
        test_kw3_timing();
        test_add_stall();
        test_out_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
